// File: rtl/divider16b.sv
// 16-bit unsigned restoring divider: one quotient bit per cycle, MSB first.
// Accepted start -> done 17 cycles later (y=0 -> done next cycle). Start is ignored while busy.
module divider16b (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] x,
  input  logic [15:0] y,
  output logic [15:0] q,
  output logic [15:0] r,
  output logic        busy,
  output logic        done,
  output logic        dbz
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_x;
  logic [15:0] r_y;
  logic [15:0] r_rem;
  logic [3:0]  r_cnt;
  logic [15:0] r_q;
  logic [15:0] r_r;
  logic        r_dbz;

  logic        w_accept;
  logic [16:0] w_shift;
  logic        w_qbit;
  logic [15:0] w_sub;
  logic [15:0] w_rem_nxt;
  logic [15:0] w_quo_nxt;

  assign w_accept  = start && (r_state != S_RUN);
  // 17-bit trial operand: remainder shifted left with the next dividend bit
  assign w_shift   = {r_rem, r_x[15]};
  assign w_qbit    = (w_shift >= {1'b0, r_y});
  assign w_sub     = w_shift[15:0] - r_y;
  assign w_rem_nxt = w_qbit ? w_sub : w_shift[15:0];
  // r_x doubles as the quotient accumulator as dividend bits shift out
  assign w_quo_nxt = {r_x[14:0], w_qbit};

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE,
      S_FIN: begin
        if (w_accept) w_next = (y == 16'd0) ? S_FIN : S_RUN;
        else          w_next = S_IDLE;
      end
      S_RUN: begin
        if (r_cnt == 4'd0) w_next = S_FIN;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      S_RUN:   busy = 1'b1;
      S_FIN:   done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x   <= 16'd0;
      r_y   <= 16'd0;
      r_rem <= 16'd0;
      r_cnt <= 4'd0;
      r_q   <= 16'd0;
      r_r   <= 16'd0;
      r_dbz <= 1'b0;
    end else if (w_accept) begin
      if (y == 16'd0) begin
        r_q   <= 16'hFFFF;
        r_r   <= x;
        r_dbz <= 1'b1;
      end else begin
        r_x   <= x;
        r_y   <= y;
        r_rem <= 16'd0;
        r_cnt <= 4'd15;
      end
    end else if (r_state == S_RUN) begin
      r_x   <= w_quo_nxt;
      r_rem <= w_rem_nxt;
      r_cnt <= r_cnt - 4'd1;
      if (r_cnt == 4'd0) begin
        r_q   <= w_quo_nxt;
        r_r   <= w_rem_nxt;
        r_dbz <= 1'b0;
      end
    end
  end

  assign q   = r_q;
  assign r   = r_r;
  assign dbz = r_dbz;

endmodule

// File: tb/tb_divider16b.sv
// Randomized self-checking bench for divider16b against a plain-arithmetic division model.
module tb_divider16b;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] x = 16'd0;
  logic [15:0] y = 16'd0;
  logic [15:0] q;
  logic [15:0] r;
  logic        busy;
  logic        done;
  logic        dbz;

  int n_vec = 0;
  int n_err = 0;

  divider16b dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .x     (x),
    .y     (y),
    .q     (q),
    .r     (r),
    .busy  (busy),
    .done  (done),
    .dbz   (dbz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Called at a negedge where the DUT can accept; returns at the negedge showing done.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input bit noise);
    int cyc;
    int nbusy;
    logic [15:0] eq;
    logic [15:0] er;
    logic        ed;
    eq = (b == 16'd0) ? 16'hFFFF : a / b;
    er = (b == 16'd0) ? a : a % b;
    ed = (b == 16'd0);
    x = a;
    y = b;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    nbusy = 0;
    while (!done && cyc < 40) begin
      nbusy += int'(busy);
      if (noise) begin
        x = 16'($urandom);
        y = 16'($urandom);
        start = 1'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("latency", cyc, (b == 16'd0) ? 0 : 16);
    chk("busy_cycles", nbusy, (b == 16'd0) ? 0 : 16);
    chk("q", q, eq);
    chk("r", r, er);
    chk("dbz", dbz, ed);
  endtask

  task automatic idle_check(input logic [15:0] eq, input logic [15:0] er, input logic ed);
    @(negedge clk);
    chk("done_pulse_width", done, 0);
    chk("idle_busy", busy, 0);
    chk("hold_q", q, eq);
    chk("hold_r", r, er);
    chk("hold_dbz", dbz, ed);
  endtask

  initial begin
    int ndone;
    int since;
    bit seen;
    logic [15:0] a;
    logic [15:0] b;

    repeat (3) @(negedge clk);
    chk("rst_q", q, 0);
    chk("rst_r", r, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dbz", dbz, 0);

    // first start coincides with the first edge without reset
    rst = 1'b0;
    do_op(16'd100, 16'd7, 1'b0);
    idle_check(16'd14, 16'd2, 1'b0);

    do_op(16'hFFFF, 16'd1, 1'b0);
    do_op(16'hFFFF, 16'hFFFF, 1'b0);
    do_op(16'd3, 16'd10, 1'b0);
    do_op(16'd5, 16'd0, 1'b0);
    idle_check(16'hFFFF, 16'd5, 1'b1);
    do_op(16'd9, 16'd2, 1'b1);
    do_op(16'd77, 16'd77, 1'b0);

    // start held high: a result every 17 cycles
    x = 16'd50;
    y = 16'd7;
    start = 1'b1;
    ndone = 0;
    since = 0;
    seen = 1'b0;
    for (int i = 0; i < 90; i++) begin
      @(negedge clk);
      since++;
      if (done) begin
        if (seen) chk("b2b_interval", since, 17);
        chk("b2b_q", q, 7);
        chk("b2b_r", r, 1);
        seen = 1'b1;
        since = 0;
        ndone++;
      end
    end
    start = 1'b0;
    chk("b2b_count", ndone, 5);
    repeat (20) @(negedge clk);

    // reset in the middle of a run
    x = 16'd200;
    y = 16'd3;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_q", q, 0);
    chk("midrst_r", r, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_dbz", dbz, 0);
    rst = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("midrst_no_done", seen, 0);
    do_op(16'd1000, 16'd33, 1'b0);

    // random sweep, bounded to keep total cycles modest
    for (int i = 0; i < 4000; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      case ($urandom_range(0, 9))
        0: b = 16'd0;
        1: b = 16'hFFFF;
        2: a = 16'hFFFF;
        3: a = 16'd0;
        4: b = 16'($urandom_range(1, 15));
        default: ;
      endcase
      do_op(a, b, 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
